// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Stall/flush controller for the five-stage pipeline: monotonic
//            stall vector, EX multicycle countdown, exception flush, watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
    parameter int unsigned STALL_LIMIT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_if,
    input  logic        stall_req_id,
    input  logic        stall_req_mem,
    input  logic        mdu_start,
    input  logic [5:0]  mdu_cycles,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    output logic        exc_ack,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        mdu_busy,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    localparam logic [15:0] c_STALL_LIMIT = STALL_LIMIT[15:0];
    localparam logic [0:0]  c_ST_RUN      = 1'b0;
    localparam logic [0:0]  c_ST_FLUSH    = 1'b1;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_next;
    logic [31:0] r_target;
    logic [15:0] r_run_len;
    logic [15:0] w_run_next;
    logic        r_timeout;
    logic [31:0] r_stall_cycles;

    logic        w_mdu_accept;
    logic        w_req_ex;
    logic        w_stall_if;
    logic        w_stall_id;
    logic        w_stall_ex;
    logic        w_stall_mem;
    logic        w_exc_ack;
    logic        w_flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN: begin
                if (w_exc_ack) begin
                    w_state_next = c_ST_FLUSH;
                end
            end
            c_ST_FLUSH: begin
                w_state_next = c_ST_RUN;
            end
            default: begin
                w_state_next = c_ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    assign w_mdu_accept = mdu_start && (mdu_cycles != 6'd0) &&
                          (r_state == c_ST_RUN) && (r_cnt == 6'd0);
    assign w_req_ex     = w_mdu_accept || (r_cnt != 6'd0);

    always_comb begin
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_stall_ex  = 1'b0;
        w_stall_mem = 1'b0;
        w_exc_ack   = 1'b0;
        w_flush     = 1'b0;
        if (rst) begin
            case (r_state)
                c_ST_RUN: begin
                    // Each stage stalls if it or any later stage requests.
                    w_stall_mem = stall_req_mem;
                    w_stall_ex  = w_stall_mem || w_req_ex;
                    w_stall_id  = w_stall_ex  || stall_req_id;
                    w_stall_if  = w_stall_id  || stall_req_if;
                    w_exc_ack   = exc_valid && !stall_req_mem;
                end
                c_ST_FLUSH: begin
                    w_flush = 1'b1;
                end
                default: begin
                    w_flush = 1'b0;
                end
            endcase
        end
    end

    assign stall_if      = w_stall_if;
    assign stall_id      = w_stall_id;
    assign stall_ex      = w_stall_ex;
    assign stall_mem     = w_stall_mem;
    assign exc_ack       = w_exc_ack;
    assign flush         = w_flush;
    assign flush_pc      = w_flush ? r_target : 32'd0;
    assign mdu_busy      = rst && (r_cnt != 6'd0);
    assign stall_timeout = rst && r_timeout;
    assign stall_cycles  = rst ? r_stall_cycles : 32'd0;

    // ------------------------------------------------------------------
    // MDU countdown, exception target capture, watchdog and statistics
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_next = r_cnt;
        if (w_exc_ack) begin
            w_cnt_next = 6'd0;
        end else if (w_mdu_accept) begin
            w_cnt_next = mdu_cycles - 6'd1;
        end else if (r_cnt != 6'd0) begin
            w_cnt_next = r_cnt - 6'd1;
        end
    end

    always_comb begin
        w_run_next = 16'd0;
        if (w_stall_if) begin
            w_run_next = (r_run_len >= c_STALL_LIMIT) ? r_run_len : r_run_len + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt          <= 6'd0;
            r_target       <= 32'd0;
            r_run_len      <= 16'd0;
            r_timeout      <= 1'b0;
            r_stall_cycles <= 32'd0;
        end else begin
            r_cnt     <= w_cnt_next;
            r_run_len <= w_run_next;
            if (w_exc_ack) begin
                r_target <= exc_target;
            end
            if (w_run_next == c_STALL_LIMIT) begin
                r_timeout <= 1'b1;
            end
            if (w_stall_if) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the five-stage pipeline. It produces the per-stage stall signals that every inter-stage pipeline register consumes as its current-stage and next-stage stall inputs. It arbitrates stall requests from IF, ID, EX and MEM, and owns the multicycle countdown for the EX-stage mult/div unit. It also sequences the exception flush and tracks stall statistics plus a deadlock watchdog.

## Interface
- STALL_LIMIT, 1023: consecutive all-stalled cycles before the watchdog trips; range 1..65535.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- stall_req_if  in  1  instruction fetch wait.
- stall_req_id  in  1  load-use hazard.
- stall_req_mem  in  1  data bus wait.
- mdu_start  in  1  EX issues a multicycle operation this cycle.
- mdu_cycles  in  6  EX stall cycles required by that operation (0..63).
- exc_valid  in  1  exception request; the source holds it until exc_ack.
- exc_target  in  32  handler PC for that request.
- exc_ack  out  1  exception accepted this cycle.
- stall_if, stall_id, stall_ex, stall_mem  out  1 each  stage stall vector.
- mdu_busy  out  1  countdown nonzero.
- flush  out  1  kill all in-flight instructions.
- flush_pc  out  32  redirect PC, valid while flush=1.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  count of cycles with stall_if=1.

## Operation
- **Stall vector.** The stall vector is monotonic: the highest requesting stage k stalls stages IF..k. Stages after k run, so the register at the k / k+1 boundary inserts a bubble.
  - IF request: stall_if only.
  - ID request: stall_if and stall_id.
  - EX request: stall_if..stall_ex.
  - MEM request: stall_if..stall_mem.
- **EX request** = (mdu_start && mdu_cycles!=0 && state==RUN && cnt==0) || cnt!=0.
- **MDU countdown.**
  - Start is accepted only when cnt==0; mdu_start while cnt!=0 is ignored.
  - Accepted start with N>0: stall_ex=1 in the start cycle, and cnt loads N-1.
  - Each later cycle with cnt!=0: EX stalled, cnt decrements.
  - Total is exactly N stalled EX cycles. The counter decrements regardless of MEM stalls.
  - N=0: no stall, cnt unchanged.
- **Flush FSM**, states RUN and FLUSH.
  - RUN: exc_ack = exc_valid && !stall_req_mem. On ack, exc_target is captured and the next state is FLUSH. Stall outputs in the ack cycle are computed normally.
  - FLUSH (exactly one cycle): flush=1, flush_pc=captured target, all stall outputs 0, exc_ack=0. Then return to RUN.
  - Entering FLUSH clears cnt to 0. mdu_start in FLUSH is ignored.
- **Watchdog.**
  - run_len (16 bit) increments on each cycle with stall_if=1 and resets to 0 on any cycle with stall_if=0.
  - When run_len reaches STALL_LIMIT, stall_timeout sets and stays set until reset. run_len saturates.
- **stall_cycles** increments on each cycle with stall_if=1 and wraps at 2^32.

## Timing
- Stall outputs, exc_ack, flush and flush_pc are combinational from the current inputs and registered state. Pipeline registers sample them in the same cycle.
- While rst=0: every output is 0 (stall_*, exc_ack, mdu_busy, flush, flush_pc, stall_timeout, stall_cycles).
- At a reset edge: state=RUN, cnt=0, captured target=0, run_len=0, counters=0.
- Reset asserted mid-countdown or in FLUSH aborts the operation, with no residual stall after rst returns to 1.
- Exception latency: the ack cycle, then flush on the following cycle. The earliest fetch from the handler is the cycle after flush.
- Simultaneous exc_valid and stall_req_mem: no ack. The request stays pending until MEM releases.
- Simultaneous ack and mdu_start: the countdown loads but is cleared on entry to FLUSH.
- A watchdog trip and a flush in the same cycle are independent; the flag still sets.

## Test plan
- **Priority.** stall_req_id=1 and stall_req_mem=0 -> if=1, id=1, ex=0, mem=0. Add stall_req_mem=1 -> all four = 1. Add only stall_req_if -> if=1, others 0.
- **MDU countdown.** mdu_start with mdu_cycles=5 -> stall_ex high for exactly 5 consecutive cycles and mdu_busy high for the last 4. A second mdu_start during the countdown does not extend it. mdu_cycles=0 -> no stall.
- **Exception.** exc_valid with exc_target=0xBFC00380 and no MEM stall -> exc_ack that cycle, then flush=1 with flush_pc=0xBFC00380 for one cycle and all stalls 0. Issue exc_valid during an MDU countdown with 3 cycles remaining -> countdown aborted and mdu_busy=0 after flush.
- **Held exception.** exc_valid with stall_req_mem=1 for 4 cycles -> exc_ack=0 for those 4 cycles, then ack on the first cycle with stall_req_mem=0.
- **Watchdog.** STALL_LIMIT=8 with stall_req_id held 7 cycles -> no timeout. One idle cycle, then held 8 cycles -> stall_timeout=1, still 1 after the stall drops. stall_cycles=15.
- **Reset.** rst=0 during cycle 2 of a 10-cycle countdown -> all outputs 0. After release with no requests: all stalls 0, stall_cycles=0.
